// File: rtl/alu_system_trace_capture.sv
// alu_system_trace_capture
// Samples ALU_System result/status outputs, tags each sample with a cycle
// stamp and buffers the records in a FIFO. A host drains the FIFO over a
// valid/ready port. Arm/trigger/stop sequencing bounds each capture run.
// Optional build macro: TRACE_CHANGE_ONLY_EN. When it is defined, a sample is
// only recorded if its payload differs from the last recorded payload.
module alu_system_trace_capture #(
  parameter int DEPTH       = 16,
  parameter int MAX_RECORDS = 16,
  parameter int STAMP_W     = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Stop,
  input  logic                       Clear,
  input  logic                       Trig_In,
  input  logic                       Sample_En,
  input  logic [7:0]                 S_ALU_Out,
  input  logic [3:0]                 S_ZCNO,
  input  logic [7:0]                 S_Mem_Addr,
  input  logic [15:0]                S_IR_Out,
  output logic [STAMP_W+37-1:0]      Rd_Data,
  output logic                       Rd_Valid,
  input  logic                       Rd_Ready,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Overflow,
  output logic [$clog2(DEPTH):0]     Level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int RW  = STAMP_W + 37;
  localparam int KW  = 36;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [STAMP_W-1:0]   stamp;
  logic [15:0]          cap_cnt;
  logic [16:0]          cnt_inc;
  logic [RW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic                 overflow;

  logic [KW-1:0]        key_cur;
  logic                 start_ok;
  logic                 stop_ok;
  logic                 qual;
  logic                 keep;
  logic                 take;
  logic                 full;
  logic                 pop;
  logic                 wr_en;
  logic                 drop;
  logic                 reach;
  logic                 busy_st;

  assign key_cur  = {S_ALU_Out, S_ZCNO, S_Mem_Addr, S_IR_Out};
  assign busy_st  = (state == S_ARMED) || (state == S_CAPTURE);
  assign start_ok = Start && ((state == S_IDLE) || (state == S_DONE));
  assign stop_ok  = Stop && (state == S_CAPTURE);
  assign full     = (level == LW'(DEPTH));
  assign Rd_Valid = (level != '0);
  assign pop      = Rd_Valid && Rd_Ready && !Clear;
  assign cnt_inc  = {1'b0, cap_cnt} + 17'd1;

`ifdef TRACE_CHANGE_ONLY_EN
  logic [KW-1:0] last_key;
  logic          first;

  assign keep = first || (key_cur != last_key);

  // Remember the payload of the last recorded sample for change detection
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      first <= 1'b1;
    end else if (start_ok) begin
      first <= 1'b1;
    end else if (take) begin
      first <= 1'b0;
    end
  end

  // Payload history is data; it only matters once first has been cleared
  always_ff @(posedge Clock) begin
    if (take) begin
      last_key <= key_cur;
    end
  end
`else
  assign keep = 1'b1;
`endif

  // A sample qualifies on the trigger cycle in ARMED or any enabled CAPTURE
  // cycle; Clear, an accepted Start and an accepted Stop all take precedence.
  always_comb begin
    qual = 1'b0;
    if (!Clear && !start_ok && !stop_ok && Sample_En) begin
      qual = ((state == S_ARMED) && Trig_In) || (state == S_CAPTURE);
    end
  end

  assign take  = qual && keep;
  assign wr_en = take && (!full || pop);
  assign drop  = take && full && !pop;
  assign reach = take && (cnt_inc == 17'(MAX_RECORDS));

  // Run-sequencing next state, priority Clear > Start > Stop > capture
  always_comb begin
    state_nxt = state;
    if (Clear) begin
      state_nxt = S_IDLE;
    end else if (start_ok) begin
      state_nxt = S_ARMED;
    end else if (stop_ok) begin
      state_nxt = S_DONE;
    end else begin
      case (state)
        S_ARMED:   if (Trig_In) state_nxt = reach ? S_DONE : S_CAPTURE;
        S_CAPTURE: if (reach)   state_nxt = S_DONE;
        default:   state_nxt = state;
      endcase
    end
  end

  // State register, cycle stamp and per-run sample count
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= S_IDLE;
      stamp   <= '0;
      cap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        stamp <= '0;
      end else if (busy_st) begin
        stamp <= stamp + STAMP_W'(1);
      end
      if (start_ok) begin
        cap_cnt <= '0;
      end else if (take) begin
        cap_cnt <= cnt_inc[15:0];
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (Clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Record storage; stamp taken before this edge's increment
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= {stamp, Trig_In, key_cur};
    end
  end

  assign Rd_Data  = Rd_Valid ? mem[rd_ptr] : '0;
  assign Busy     = busy_st;
  assign Done     = (state == S_DONE);
  assign Overflow = overflow;
  assign Level    = level;

endmodule

// File: tb/tb_alu_system_trace_capture.sv
// Directed bench for alu_system_trace_capture: main instance with
// MAX_RECORDS=20 (lets the FIFO overflow) and a second with MAX_RECORDS=4
// for auto-stop, both driven by the same stimulus.
module tb_alu_system_trace_capture;

  localparam int DEPTH   = 16;
  localparam int STAMP_W = 16;
  localparam int RW      = STAMP_W + 37;
  localparam logic [3:0]  ZC = 4'hA;
  localparam logic [7:0]  AD = 8'h3C;
  localparam logic [15:0] IR = 16'h1234;

  logic          Clock = 1'b0;
  logic          Reset, Start, Stop, Clear, Trig_In, Sample_En, Rd_Ready;
  logic [7:0]    S_ALU_Out;
  logic [3:0]    S_ZCNO;
  logic [7:0]    S_Mem_Addr;
  logic [15:0]   S_IR_Out;

  logic [RW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [4:0]    level_a, level_b;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  alu_system_trace_capture #(.DEPTH(DEPTH), .MAX_RECORDS(20), .STAMP_W(STAMP_W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Clear(Clear),
    .Trig_In(Trig_In), .Sample_En(Sample_En), .S_ALU_Out(S_ALU_Out), .S_ZCNO(S_ZCNO),
    .S_Mem_Addr(S_Mem_Addr), .S_IR_Out(S_IR_Out), .Rd_Data(rd_data_a), .Rd_Valid(rd_valid_a),
    .Rd_Ready(Rd_Ready), .Busy(busy_a), .Done(done_a), .Overflow(ovf_a), .Level(level_a)
  );

  alu_system_trace_capture #(.DEPTH(DEPTH), .MAX_RECORDS(4), .STAMP_W(STAMP_W)) dut4 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Clear(Clear),
    .Trig_In(Trig_In), .Sample_En(Sample_En), .S_ALU_Out(S_ALU_Out), .S_ZCNO(S_ZCNO),
    .S_Mem_Addr(S_Mem_Addr), .S_IR_Out(S_IR_Out), .Rd_Data(rd_data_b), .Rd_Valid(rd_valid_b),
    .Rd_Ready(Rd_Ready), .Busy(busy_b), .Done(done_b), .Overflow(ovf_b), .Level(level_b)
  );

  function automatic logic [RW-1:0] rec(input int st, input logic tr, input int alu);
    return {16'(st), tr, 8'(alu), ZC, AD, IR};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    Clear = 1'b1; tick(); Clear = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0; Start = 1'b0; Stop = 1'b0; Clear = 1'b0; Trig_In = 1'b0;
    Sample_En = 1'b0; Rd_Ready = 1'b0;
    S_ALU_Out = 8'h00; S_ZCNO = ZC; S_Mem_Addr = AD; S_IR_Out = IR;
    tick(); tick();
    Reset = 1'b1;

    // reset state
    chk("rst_level", level_a, 0);
    chk("rst_valid", rd_valid_a, 0);
    chk("rst_data",  rd_data_a, 0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_ovf",   ovf_a, 0);

    // Stop outside CAPTURE is ignored
    Stop = 1'b1; tick(); Stop = 1'b0;
    chk("stop_idle_done", done_a, 0);

    // basic run: trigger three cycles after Start, four samples
    pulse_start();
    chk("armed_busy", busy_a, 1);
    tick(); tick(); tick();
    Trig_In = 1'b1; Sample_En = 1'b1; S_ALU_Out = 8'h05; tick();
    Trig_In = 1'b0;
    S_ALU_Out = 8'h06; tick();
    S_ALU_Out = 8'h07; tick();
    S_ALU_Out = 8'h08; tick();
    Sample_En = 1'b0; Stop = 1'b1; tick(); Stop = 1'b0;
    chk("run1_done",  done_a, 1);
    chk("run1_busy",  busy_a, 0);
    chk("run1_level", level_a, 4);
    Rd_Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("run1_valid", rd_valid_a, 1);
      chk("run1_rec", rd_data_a, rec(3 + k, (k == 0), 5 + k));
      tick();
    end
    Rd_Ready = 1'b0;
    chk("run1_empty_valid", rd_valid_a, 0);
    chk("run1_empty_level", level_a, 0);

    // long run: auto-stop at 4 (dut4) and overflow past DEPTH (dut)
    pulse_start();
    Trig_In = 1'b1; Sample_En = 1'b1;
    for (int i = 0; i < 20; i++) begin
      S_ALU_Out = 8'(i);
      tick();
      Trig_In = 1'b0;
      if (i == 9) begin
        chk("max4_level", level_b, 4);
        chk("max4_done",  done_b, 1);
        chk("max4_ovf",   ovf_b, 0);
        chk("run2_level10", level_a, 10);
        chk("run2_busy10",  busy_a, 1);
      end
      if (i == 15) begin
        chk("run2_full_level", level_a, 16);
        chk("run2_full_ovf",   ovf_a, 0);
      end
      if (i == 16) begin
        chk("run2_drop_level", level_a, 16);
        chk("run2_drop_ovf",   ovf_a, 1);
      end
    end
    Sample_En = 1'b0;
    chk("run2_done",  done_a, 1);
    chk("run2_level", level_a, 16);
    chk("run2_ovf",   ovf_a, 1);
    chk("run2_head", rd_data_a, rec(0, 1'b1, 0));
    tick();
    chk("run2_head_stable", rd_data_a, rec(0, 1'b1, 0));
    Rd_Ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("run2_rec", rd_data_a, rec(k, (k == 0), k));
      tick();
    end
    Rd_Ready = 1'b0;
    chk("run2_drained", rd_valid_a, 0);

    // full FIFO with simultaneous read and write
    pulse_clear();
    chk("clr_level", level_a, 0);
    chk("clr_ovf",   ovf_a, 0);
    chk("clr_idle",  busy_a | done_a, 0);
    pulse_start();
    Trig_In = 1'b1; Sample_En = 1'b1;
    for (int i = 0; i < 16; i++) begin
      S_ALU_Out = 8'(i);
      tick();
      Trig_In = 1'b0;
    end
    chk("rw_pre_level", level_a, 16);
    Rd_Ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      S_ALU_Out = 8'(16 + k);
      tick();
      chk("rw_level", level_a, 16);
      chk("rw_ovf",   ovf_a, 0);
    end
    Rd_Ready = 1'b0; Sample_En = 1'b0;
    chk("rw_head", rd_data_a, rec(3, 1'b0, 3));

    // reset in the middle of a capture
    pulse_clear();
    pulse_start();
    Trig_In = 1'b1; Sample_En = 1'b1;
    for (int i = 0; i < 5; i++) begin
      S_ALU_Out = 8'(i);
      tick();
      Trig_In = 1'b0;
    end
    chk("mid_level", level_a, 5);
    chk("mid_busy",  busy_a, 1);
    Reset = 1'b0; tick(); Reset = 1'b1; Sample_En = 1'b0;
    chk("mid_rst_level", level_a, 0);
    chk("mid_rst_valid", rd_valid_a, 0);
    chk("mid_rst_busy",  busy_a, 0);

`ifdef TRACE_CHANGE_ONLY_EN
    // change-only: repeated payloads are suppressed
    pulse_start();
    Trig_In = 1'b1; Sample_En = 1'b1; S_ALU_Out = 8'h10; tick();
    Trig_In = 1'b0;
    tick(); tick();
    S_ALU_Out = 8'h11; tick();
    Sample_En = 1'b0;
    chk("chg_level", level_a, 2);
    chk("chg_rec0", rd_data_a, rec(0, 1'b1, 8'h10));
    Rd_Ready = 1'b1; tick(); Rd_Ready = 1'b0;
    chk("chg_rec1", rd_data_a, rec(3, 1'b0, 8'h11));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
